// File: rtl/game_pkg.sv
// Shared game constants: transition FSM state encoding, hero start and goal
// coordinates, score step and screen size.
package game_pkg;

  typedef enum logic [2:0] {
    PLAY   = 3'd0,
    FADE   = 3'd1,
    BANNER = 3'd2,
    LOAD   = 3'd3,
    WON    = 3'd4
  } lt_state_t;

  localparam int unsigned DEF_FADE_FRAMES   = 30;
  localparam int unsigned DEF_BANNER_FRAMES = 120;
  localparam int unsigned DEF_MAX_LEVEL     = 8;

  localparam logic [11:0] HERO1_X_START = 12'd402;
  localparam logic [11:0] HERO2_X_START = 12'd562;
  localparam logic [11:0] HERO_Y_START  = 12'd668;

  // The level manager tests the same goal point, so it lives here only once.
  localparam logic [11:0] GOAL_X = 12'd482;
  localparam logic [11:0] GOAL_Y = 12'd108;

  localparam int unsigned SCORE_STEP = 1000;
  localparam int unsigned SCREEN_W   = 1024;
  localparam int unsigned SCREEN_H   = 768;

endpackage

// File: rtl/level_transition_ctrl_if.sv
// Level-manager and hero/banner facing signals of the level transition controller.
interface level_transition_ctrl_if;
  logic        frame_tick;
  logic        hero_rst;
  logic [9:0]  level;
  logic        game_freeze;
  logic        hero_pos_load;
  logic [23:0] hero_x_init;
  logic [23:0] hero_y_init;
  logic        fade_active;
  logic [7:0]  fade_step;
  logic        banner_en;
  logic [9:0]  banner_level;
  logic        game_won;

  modport master (
    output frame_tick, hero_rst, level,
    input  game_freeze, hero_pos_load, hero_x_init, hero_y_init,
           fade_active, fade_step, banner_en, banner_level, game_won
  );

  modport slave (
    input  frame_tick, hero_rst, level,
    output game_freeze, hero_pos_load, hero_x_init, hero_y_init,
           fade_active, fade_step, banner_en, banner_level, game_won
  );
endinterface

// File: rtl/level_transition_ctrl_frame_timer.sv
// 8-bit frame counter with synchronous clear, increment enable and a
// terminal-count flag against a run-time selectable limit.
module frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] term,
  output logic [7:0] count,
  output logic       tc
);
  logic [7:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= 8'd0;
    end else if (inc) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == term);
endmodule

// File: rtl/level_transition_ctrl.sv
// Sequences level changes: freeze, fade out, level banner, hero reload, resume;
// also covers power-up start and the sticky game-won lock.
module level_transition_ctrl
  import game_pkg::*;
#(
  parameter int unsigned FADE_FRAMES   = DEF_FADE_FRAMES,
  parameter int unsigned BANNER_FRAMES = DEF_BANNER_FRAMES,
  parameter int unsigned MAX_LEVEL     = DEF_MAX_LEVEL,
  parameter logic [11:0] HERO1_X_INIT  = HERO1_X_START,
  parameter logic [11:0] HERO2_X_INIT  = HERO2_X_START,
  parameter logic [11:0] HERO_Y_INIT   = HERO_Y_START
) (
  input logic clk,
  input logic rst,
  level_transition_ctrl_if.slave lt
);
  localparam logic [7:0] FADE_TERM   = 8'(FADE_FRAMES - 1);
  localparam logic [7:0] BANNER_TERM = 8'(BANNER_FRAMES - 1);
  localparam logic [9:0] MAX_LVL     = 10'(MAX_LEVEL);

  lt_state_t  state_reg;
  logic       freeze_reg;
  logic       pos_load_reg;
  logic       fade_active_reg;
  logic [7:0] fade_step_reg;
  logic       banner_en_reg;
  logic [9:0] banner_level_reg;
  logic       won_reg;
  logic [9:0] level_lat_reg;

  logic       counting;
  logic       last_tick;
  logic       timer_inc;
  logic       timer_clr;
  logic [7:0] timer_term;
  logic [7:0] timer_count;
  logic       timer_tc;

  // The timer only runs in FADE/BANNER; it is cleared on the terminal tick so
  // the next phase starts from zero without an extra cycle.
  always_comb begin
    counting   = (state_reg == FADE) || (state_reg == BANNER);
    timer_term = (state_reg == FADE) ? FADE_TERM : BANNER_TERM;
    last_tick  = lt.frame_tick && counting && timer_tc;
    timer_inc  = lt.frame_tick && counting && !timer_tc;
    timer_clr  = !counting || last_tick;
  end

  frame_timer u_frame_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .inc   (timer_inc),
    .term  (timer_term),
    .count (timer_count),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= BANNER;
      freeze_reg       <= 1'b1;
      pos_load_reg     <= 1'b0;
      fade_active_reg  <= 1'b0;
      fade_step_reg    <= 8'd0;
      banner_en_reg    <= 1'b1;
      banner_level_reg <= 10'd1;
      won_reg          <= 1'b0;
      level_lat_reg    <= 10'd0;
    end else begin
      pos_load_reg <= 1'b0;
      case (state_reg)
        PLAY: begin
          if (lt.hero_rst) begin
            state_reg       <= FADE;
            freeze_reg      <= 1'b1;
            fade_active_reg <= 1'b1;
            fade_step_reg   <= 8'd0;
            level_lat_reg   <= lt.level;
          end
        end
        FADE: begin
          if (last_tick) begin
            fade_active_reg <= 1'b0;
            fade_step_reg   <= 8'd0;
            if (level_lat_reg >= MAX_LVL) begin
              state_reg <= WON;
              won_reg   <= 1'b1;
            end else begin
              state_reg        <= BANNER;
              banner_en_reg    <= 1'b1;
              banner_level_reg <= level_lat_reg + 10'd1;
            end
          end else if (lt.frame_tick) begin
            fade_step_reg <= timer_count + 8'd1;
          end
        end
        BANNER: begin
          if (last_tick) begin
            state_reg     <= LOAD;
            banner_en_reg <= 1'b0;
            pos_load_reg  <= 1'b1;
          end
        end
        LOAD: begin
          state_reg  <= PLAY;
          freeze_reg <= 1'b0;
        end
        WON: begin
          state_reg <= WON;
        end
        default: begin
          state_reg <= BANNER;
        end
      endcase
    end
  end

  logic [23:0] hero_x_w;
  logic [23:0] hero_y_w;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hero
      localparam logic [11:0] X_INIT = (gi == 0) ? HERO1_X_INIT : HERO2_X_INIT;
      assign hero_x_w[gi*12 +: 12] = X_INIT;
      assign hero_y_w[gi*12 +: 12] = HERO_Y_INIT;
    end
  endgenerate

  assign lt.game_freeze   = freeze_reg;
  assign lt.hero_pos_load = pos_load_reg;
  assign lt.hero_x_init   = hero_x_w;
  assign lt.hero_y_init   = hero_y_w;
  assign lt.fade_active   = fade_active_reg;
  assign lt.fade_step     = fade_step_reg;
  assign lt.banner_en     = banner_en_reg;
  assign lt.banner_level  = banner_level_reg;
  assign lt.game_won      = won_reg;
endmodule

// File: tb/tb_level_transition_ctrl.sv
// Directed bench for level_transition_ctrl with short fade/banner lengths and
// MAX_LEVEL=2; one frame_tick every 10 clocks.
module tb_level_transition_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  level_transition_ctrl_if bus ();

  level_transition_ctrl #(
    .FADE_FRAMES   (3),
    .BANNER_FRAMES (4),
    .MAX_LEVEL     (2),
    .HERO1_X_INIT  (12'd402),
    .HERO2_X_INIT  (12'd562),
    .HERO_Y_INIT   (12'd668)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lt  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-18s got=%0h want=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-18s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; returns 1ns after the edge.
  task automatic cyc(input logic tick, input logic hr, input logic [9:0] lv);
    bus.frame_tick = tick;
    bus.hero_rst   = hr;
    bus.level      = lv;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.hero_rst   = 1'b0;
  endtask

  // n frames: nine quiet clocks then the tick clock, so the n-th tick edge has just passed.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 9; j++) cyc(1'b0, 1'b0, 10'd0);
      cyc(1'b1, 1'b0, 10'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.hero_rst   = 1'b0;
    bus.level      = 10'd0;
    cyc(1'b1, 1'b1, 10'd5);
    cyc(1'b0, 1'b0, 10'd0);
    check("rst_freeze", 32'(bus.game_freeze), 32'd1);
    check("rst_banner_en", 32'(bus.banner_en), 32'd1);
    check("rst_banner_lvl", 32'(bus.banner_level), 32'd1);
    check("rst_load", 32'(bus.hero_pos_load), 32'd0);
    check("rst_fade", {23'd0, bus.fade_active, bus.fade_step}, 32'd0);
    check("rst_won", 32'(bus.game_won), 32'd0);
    check("rst_x_init", 32'(bus.hero_x_init), 32'h232192);
    rst = 1'b0;

    // Power-up banner runs four ticks then loads heroes.
    ticks(3);
    check("pu_banner_hold", {30'd0, bus.banner_en, bus.hero_pos_load}, 32'd2);
    ticks(1);
    check("pu_load", 32'(bus.hero_pos_load), 32'd1);
    check("pu_load_freeze", 32'(bus.game_freeze), 32'd1);
    check("pu_x_init", 32'(bus.hero_x_init), 32'h232192);
    check("pu_y_init", 32'(bus.hero_y_init), 32'h29C29C);
    cyc(1'b0, 1'b0, 10'd0);
    check("pu_play_load", 32'(bus.hero_pos_load), 32'd0);
    check("pu_play_freeze", 32'(bus.game_freeze), 32'd0);
    ticks(2);
    check("play_idle", {29'd0, bus.game_freeze, bus.banner_en, bus.fade_active}, 32'd0);

    // Level 1 complete: fade 3 ticks, banner shows 2.
    cyc(1'b0, 1'b1, 10'd1);
    check("l1_freeze", 32'(bus.game_freeze), 32'd1);
    check("l1_fade_act", 32'(bus.fade_active), 32'd1);
    check("l1_step0", 32'(bus.fade_step), 32'd0);
    ticks(1);
    check("l1_step1", 32'(bus.fade_step), 32'd1);
    ticks(1);
    check("l1_step2", 32'(bus.fade_step), 32'd2);
    ticks(1);
    check("l1_banner_en", 32'(bus.banner_en), 32'd1);
    check("l1_banner_lvl", 32'(bus.banner_level), 32'd2);
    check("l1_fade_off", 32'(bus.fade_active), 32'd0);
    cyc(1'b0, 1'b1, 10'd5);
    check("bn_ignore_hr", 32'(bus.banner_level), 32'd2);
    ticks(3);
    check("bn_hold", {30'd0, bus.banner_en, bus.hero_pos_load}, 32'd2);
    ticks(1);
    check("bn_load", 32'(bus.hero_pos_load), 32'd1);
    cyc(1'b0, 1'b0, 10'd0);
    check("bn_load_once", 32'(bus.hero_pos_load), 32'd0);
    check("bn_play", 32'(bus.game_freeze), 32'd0);

    // hero_rst together with a tick: the tick is not counted.
    cyc(1'b1, 1'b1, 10'd1);
    check("co_step0", 32'(bus.fade_step), 32'd0);
    ticks(1);
    check("co_step1", 32'(bus.fade_step), 32'd1);
    cyc(1'b0, 1'b1, 10'd7);
    check("fd_ignore_hr", {23'd0, bus.fade_active, bus.fade_step}, 32'h101);
    ticks(1);
    check("co_step2", 32'(bus.fade_step), 32'd2);
    ticks(1);
    check("co_banner_lvl", 32'(bus.banner_level), 32'd2);
    ticks(2);

    // Reset mid-banner with counter at 2.
    rst = 1'b1;
    cyc(1'b0, 1'b0, 10'd0);
    check("rb_banner_lvl", 32'(bus.banner_level), 32'd1);
    check("rb_freeze_en", {30'd0, bus.game_freeze, bus.banner_en}, 32'd3);
    rst = 1'b0;
    ticks(3);
    check("rb_cnt_cleared", {30'd0, bus.banner_en, bus.hero_pos_load}, 32'd2);
    ticks(1);
    check("rb_load", 32'(bus.hero_pos_load), 32'd1);
    cyc(1'b0, 1'b0, 10'd0);

    // Final level: fade ends in WON.
    cyc(1'b0, 1'b1, 10'd2);
    ticks(3);
    check("won", 32'(bus.game_won), 32'd1);
    check("won_outputs", {29'd0, bus.game_freeze, bus.banner_en, bus.fade_active}, 32'd4);
    cyc(1'b0, 1'b1, 10'd2);
    ticks(2);
    check("won_sticky", {28'd0, bus.game_won, bus.game_freeze, bus.banner_en, bus.fade_active}, 32'hC);

    rst = 1'b1;
    cyc(1'b0, 1'b0, 10'd0);
    check("rw_won", 32'(bus.game_won), 32'd0);
    check("rw_banner", {20'd0, bus.banner_en, 1'b0, bus.banner_level}, 32'h801);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 10'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/level_transition_ctrl.md
Name: level_transition_ctrl

Overview:
- Sits at the consumer end of the level-management interface: takes the `hero_rst` pulse and `level` value produced by the level manager.
- Sequences each level change: freeze gameplay, fade out, show "LEVEL N" banner, reload both heroes' start positions, resume play.
- Drives the freeze/load controls for the hero movement units and the enable/level for the banner renderer.
- Also handles power-up start and the final-level "game won" lock.

Parameters:
- FADE_FRAMES, 30, frame ticks spent in fade-out (1..255)
- BANNER_FRAMES, 120, frame ticks the level banner is shown (1..255)
- MAX_LEVEL, 8, level value that ends the game (won)
- HERO1_X_INIT, 402, hero 1 start x (12 bit)
- HERO2_X_INIT, 562, hero 2 start x (12 bit)
- HERO_Y_INIT, 668, start y for both heroes (12 bit)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- hero_rst  in  1  level-complete pulse from level manager
- level  in  10  current level from level manager (already incremented when hero_rst is high)
- game_freeze  out  1  high = hero/enemy motion halted
- hero_pos_load  out  1  one-cycle pulse: heroes load init positions
- hero_x_init  out  24  {HERO2_X_INIT, HERO1_X_INIT}, [11:0] = hero 1
- hero_y_init  out  24  {HERO_Y_INIT, HERO_Y_INIT}
- fade_active  out  1  fade-out in progress
- fade_step  out  8  frame ticks elapsed in fade (0..FADE_FRAMES-1)
- banner_en  out  1  show level banner
- banner_level  out  10  level number to display (latched level + 1)
- game_won  out  1  sticky win indication

Behaviour:
- All outputs registered. hero_x_init/hero_y_init are constants, valid in every state including reset.
- Reset values:
  - state = BANNER
  - game_freeze = 1
  - hero_pos_load = 0
  - fade_active = 0, fade_step = 0
  - banner_en = 1, banner_level = 1
  - game_won = 0
  - frame counter = 0
- States:
  - PLAY: game_freeze = 0, banner_en = 0. On hero_rst = 1, the next cycle enters FADE with freeze = 1, fade_active = 1, counter = 0, and latches level. hero_rst in any other state is ignored (the level manager cannot fire while frozen heroes sit off goal; ignoring is mandatory anyway).
  - FADE: each frame_tick increments the counter; fade_step follows the counter. On the tick where counter == FADE_FRAMES-1:
    - if latched level >= MAX_LEVEL, go to WON;
    - else go to BANNER with counter = 0, fade_active = 0, banner_en = 1, banner_level = latched + 1.
  - BANNER: freeze = 1. Each frame_tick increments the counter. On the tick where counter == BANNER_FRAMES-1, go to LOAD with banner_en = 0.
  - LOAD: exactly one cycle. hero_pos_load = 1. Next state is PLAY; freeze drops to 0 in that same next cycle. Heroes therefore resume from the init positions on the first unfrozen cycle.
  - WON: freeze = 1, game_won = 1, fade_active = 0, banner_en = 0. Stays until rst.
- Timing:
  - Durations count frame_tick pulses, not clocks. Cycles without a tick hold the counter.
  - The counter is 8 bits. It never exceeds max(FADE_FRAMES, BANNER_FRAMES)-1 and never wraps.
  - Latency hero_rst → game_freeze = 1 is exactly 1 clock.
- Simultaneous events:
  - hero_rst with frame_tick in PLAY: the tick is not counted; FADE starts at counter 0.
  - rst with anything: rst wins, and the block returns to the reset values mid-fade/banner/WON.
- banner_level uses 10-bit +1 and wraps at 1023 → 0 (unreachable for MAX_LEVEL < 1023).
- At power-up the first banner shows 1 and ends with LOAD. Play always starts from positions loaded by this block.

Decomposition:
- Shared game package (game_pkg) holds:
  - state encoding constants (PLAY, FADE, BANNER, LOAD, WON)
  - hero start coordinates
  - goal coordinates (482,108), so the level manager and this block share one source
  - score step 1000 and screen dimensions
- One natural sub-module: frame_timer. It is an 8-bit frame_tick counter with clear, enable and terminal-count output, reused for both FADE and BANNER. The FSM remains in level_transition_ctrl.

Test Plan (FADE_FRAMES=3, BANNER_FRAMES=4, MAX_LEVEL=2, frame_tick every 10 clocks):
1. Release rst → banner_en=1, banner_level=1, freeze=1. After the 4th tick: one-cycle hero_pos_load, hero_x_init=0x232_192, hero_y_init=0x29C_29C, then freeze=0.
2. In PLAY, pulse hero_rst with level=1 → next clock freeze=1, fade_active=1, fade_step=0. fade_step reaches 1, 2 on the next ticks; 3rd tick → banner_en=1, banner_level=2.
3. Continue scenario 2: after 4 banner ticks → hero_pos_load high for exactly 1 cycle, then PLAY. Ticks with no clock gaps change nothing else.
4. hero_rst with level=2 → after 3 fade ticks, game_won=1, banner_en=0, freeze=1. A further hero_rst and ticks keep the WON state.
5. hero_rst pulsed during BANNER and during FADE → ignored, no timing change. hero_rst coincident with frame_tick in PLAY → fade_step still starts at 0.
6. Assert rst mid-BANNER (counter=2) and mid-WON → next cycle reset values, banner_level=1, game_won=0, counter 0.
